// File: rtl/pl_dmem_arbiter.sv
// Data-memory arbiter between the MEM-stage CPU port and a DMA/debug port with starvation guard.
// Define DMEM_ARB_RR_EN for round-robin contention below the starvation limit; default build gives CPU priority.
module pl_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  owner_t           last_owner;
  owner_t           last_owner_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             rvalid_nxt;
  logic [31:0]      rdata_nxt;
  logic             cpu_win;
  logic             dma_win;

  // State register: reset drops any in-flight request and clears starvation history.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_owner <= OWN_NONE;
      wait_cnt   <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      last_owner <= last_owner_nxt;
      wait_cnt   <= wait_cnt_nxt;
      dma_rvalid <= rvalid_nxt;
      dma_rdata  <= rdata_nxt;
    end
  end

  // Winner selection, memory mux and next-state.
  always_comb begin
    cpu_win        = 1'b0;
    dma_win        = 1'b0;
    last_owner_nxt = last_owner;
    wait_cnt_nxt   = wait_cnt;
    rvalid_nxt     = 1'b0;
    rdata_nxt      = dma_rdata;
    cpu_rdata      = '0;
    cpu_stall      = 1'b0;
    dma_gnt        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_datain     = '0;

    if (clrn) begin
      if (cpu_req && dma_req) begin
        if (wait_cnt == LIMIT) begin
          dma_win = 1'b1;
`ifdef DMEM_ARB_RR_EN
        end else if (last_owner == OWN_CPU) begin
          dma_win = 1'b1;
        end else begin
          cpu_win = 1'b1;
`else
        end else begin
          cpu_win = 1'b1;
`endif
        end
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else if (dma_req) begin
        dma_win = 1'b1;
      end
    end

    if (cpu_win) begin
      mem_we         = cpu_we;
      mem_addr       = cpu_addr;
      mem_datain     = cpu_wdata;
      cpu_rdata      = mem_dataout;
      last_owner_nxt = OWN_CPU;
    end else if (dma_win) begin
      mem_we         = dma_we;
      mem_addr       = dma_addr;
      mem_datain     = dma_wdata;
      dma_gnt        = 1'b1;
      cpu_stall      = cpu_req;
      last_owner_nxt = OWN_DMA;
      rvalid_nxt     = ~dma_we;
      rdata_nxt      = dma_we ? dma_rdata : mem_dataout;
    end

    // Count consecutive refused DMA cycles, saturating at the limit.
    if (!dma_req || dma_win) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pl_dmem_arbiter.md
PL_DMEM_ARBITER -- requirements
Module: pl_dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive refused DMA cycles after which DMA is forced to win.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_req  input  1  MEM-stage access request (lw or sw).
REQ-005 SHALL have port cpu_we  input  1  CPU write (sw).
REQ-006 SHALL have ports cpu_addr, cpu_wdata  input  32 each  CPU byte address and store data.
REQ-007 SHALL have port cpu_rdata  output  32  CPU load data.
REQ-008 SHALL have port cpu_stall  output  1  pipeline stall; CPU access not performed this cycle.
REQ-009 SHALL have ports dma_req, dma_we  input  1 each  DMA/debug request and write flag.
REQ-010 SHALL have ports dma_addr, dma_wdata  input  32 each  DMA byte address and write data.
REQ-011 SHALL have port dma_gnt  output  1  DMA access performed this cycle.
REQ-012 SHALL have ports dma_rvalid (1) and dma_rdata (32)  output  registered DMA read response.
REQ-013 SHALL have ports mem_we (1), mem_addr (32), mem_datain (32)  output  drive data memory; mem_dataout  input  32  combinational memory read data.

Function
- REQ-014 SHALL perform at most one memory access per cycle; the winner is selected combinationally from current requests and registered state.
- REQ-015 SHALL keep state registers last_owner {NONE, CPU, DMA} and wait_cnt (width ceil(log2(STARVE_LIMIT+1))).
- REQ-016 Only cpu_req: CPU wins; cpu_stall=0.
- REQ-017 Only dma_req: DMA wins; dma_gnt=1.
- REQ-018 Both, wait_cnt==STARVE_LIMIT: DMA wins, cpu_stall=1.
- REQ-019 Both, wait_cnt<STARVE_LIMIT: winner per Configuration; loser CPU gets cpu_stall=1, loser DMA gets dma_gnt=0.
- REQ-020 Neither: mem_we=0, mem_addr=0, mem_datain=0, cpu_stall=0, dma_gnt=0.
- REQ-021 mem_addr/mem_datain SHALL carry the winner's address/data unmodified; mem_we = winner's we.
- REQ-022 cpu_rdata SHALL equal mem_dataout when CPU wins, else 0 (zero-latency load).
- REQ-023 Granted DMA read (dma_we=0): next edge dma_rvalid<=1, dma_rdata<=mem_dataout; any other cycle dma_rvalid<=0, dma_rdata holds.
- REQ-024 wait_cnt: +1 (saturating at STARVE_LIMIT) each cycle dma_req=1 and dma_gnt=0; cleared when dma_gnt=1 or dma_req=0.
- REQ-025 last_owner updated each edge to the cycle's winner; unchanged when no winner.
- REQ-026 cpu_stall SHALL never assert when cpu_req=0; stalled requesters keep requests stable (requester obligation; arbiter does not latch requests).

Reset
- REQ-027 clrn low SHALL immediately force last_owner=NONE, wait_cnt=0, dma_rvalid=0, dma_rdata=0.
- REQ-028 While clrn low: mem_we=0, dma_gnt=0, cpu_stall=0, cpu_rdata=0; a request in flight at reset is dropped, not replayed.

Configuration
- REQ-029 Macro DMEM_ARB_RR_EN defined: on contention below starvation limit, winner is the opposite of last_owner (NONE treated as DMA, so CPU wins first).
- REQ-030 Macro undefined: on contention below starvation limit, CPU always wins; starvation rule REQ-018 still applies.

Verification
- REQ-031 Memory word 0x14=0x000000f2; cpu_req=1, cpu_addr=0x50, dma_req=0 -> same cycle cpu_rdata=0x000000f2, cpu_stall=0.
- REQ-032 dma_req=1, dma_we=0, dma_addr=0x54 (word 0x0000000e), cpu_req=0 -> dma_gnt=1; next cycle dma_rvalid=1, dma_rdata=0x0000000e; following cycle dma_rvalid=0.
- REQ-033 Macro undefined, cpu_req and dma_req held 1 from cycle 0 -> cycles 0-3 CPU wins with dma_gnt=0; cycle 4 dma_gnt=1, cpu_stall=1; cycle 5 CPU wins.
- REQ-034 Macro defined, both held 1 from reset -> winners alternate CPU, DMA, CPU, DMA; cpu_stall=1 exactly on DMA cycles.
- REQ-035 DMA write dma_addr=0x60, dma_wdata=0x00000200 granted -> mem_we=1, mem_addr=0x60 that cycle; later CPU read 0x60 returns 0x00000200.
- REQ-036 clrn pulsed low asynchronously between edges with wait_cnt=3 and dma_rvalid=1 -> both 0 immediately, mem_we=0 while low; after release, 4 further refused cycles needed before forced DMA win.
